// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter that shares one APB master between NUM_REQ requesters.
// The winner's command is latched, the master gets a single start pulse with
// sel held until the completing cycle, and the winner gets rdata plus exactly
// one done or err pulse. A watchdog aborts transfers that never complete.
module apb_request_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      m_start,
    output logic                      m_write,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [SEL_W-1:0]          m_sel,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_stable,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    // A zero-width counter is illegal, so a disabled watchdog keeps one idle bit.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ABORT} state_t;

    state_t state, state_d;

    logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
    logic               cmd_write, cmd_write_d;
    logic [ADDR_W-1:0]  cmd_addr, cmd_addr_d;
    logic [DATA_W-1:0]  cmd_wdata, cmd_wdata_d;
    logic [SEL_W-1:0]   cmd_sel, cmd_sel_d;
    logic [WD_W-1:0]    wd_cnt, wd_cnt_d;

    logic [NUM_REQ-1:0] grant_d, done_d, err_d;
    logic [DATA_W-1:0]  rdata_d, m_wdata_d;
    logic               m_start_d, m_write_d, busy_d;
    logic [ADDR_W-1:0]  m_addr_d;
    logic [SEL_W-1:0]   m_sel_d;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;
    logic               win_write;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [SEL_W-1:0]   win_sel;

    // Round-robin search: first valid requester after the previous winner.
    always_comb begin
        found   = 1'b0;
        win_idx = rr_ptr;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Unpack the winning requester's command fields.
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_write = req_write[i];
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
                win_sel   = req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        cmd_write_d = cmd_write;
        cmd_addr_d  = cmd_addr;
        cmd_wdata_d = cmd_wdata;
        cmd_sel_d   = cmd_sel;
        wd_cnt_d    = wd_cnt;
        grant_d     = req_grant;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = req_rdata;
        m_start_d   = 1'b0;
        m_write_d   = m_write;
        m_addr_d    = m_addr;
        m_wdata_d   = m_wdata;
        m_sel_d     = m_sel;

        unique case (state)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_START;
                    rr_ptr_d    = win_idx;
                    cmd_write_d = win_write;
                    cmd_addr_d  = win_addr;
                    cmd_wdata_d = win_wdata;
                    cmd_sel_d   = win_sel;
                    grant_d     = NUM_REQ'(1) << win_idx;
                end
            end
            S_START: begin
                state_d   = S_WAIT;
                m_start_d = 1'b1;
                m_write_d = cmd_write;
                m_addr_d  = cmd_addr;
                m_wdata_d = cmd_wdata;
                m_sel_d   = cmd_sel;
                wd_cnt_d  = '0;
            end
            S_WAIT: begin
                // A completion in the same cycle as the timeout wins.
                if (m_stable) begin
                    state_d = S_DONE;
                    rdata_d = m_rdata;
                end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
                    state_d = S_ABORT;
                end else if (wd_cnt != {WD_W{1'b1}}) begin
                    wd_cnt_d = wd_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = NUM_REQ'(1) << rr_ptr;
                grant_d = '0;
                m_sel_d = '0;
            end
            S_ABORT: begin
                state_d = S_IDLE;
                err_d   = NUM_REQ'(1) << rr_ptr;
                grant_d = '0;
                m_sel_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Command latches, watchdog and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the command latches are reset too, so nothing downstream ever sees X after reset.
        if (!reset) begin
            rr_ptr    <= PTR_RST;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_sel   <= '0;
            wd_cnt    <= '0;
            req_grant <= '0;
            req_done  <= '0;
            req_err   <= '0;
            req_rdata <= '0;
            m_start   <= 1'b0;
            m_write   <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_sel     <= '0;
            busy      <= 1'b0;
        end else begin
            rr_ptr    <= rr_ptr_d;
            cmd_write <= cmd_write_d;
            cmd_addr  <= cmd_addr_d;
            cmd_wdata <= cmd_wdata_d;
            cmd_sel   <= cmd_sel_d;
            wd_cnt    <= wd_cnt_d;
            req_grant <= grant_d;
            req_done  <= done_d;
            req_err   <= err_d;
            req_rdata <= rdata_d;
            m_start   <= m_start_d;
            m_write   <= m_write_d;
            m_addr    <= m_addr_d;
            m_wdata   <= m_wdata_d;
            m_sel     <= m_sel_d;
            busy      <= busy_d;
        end
    end

endmodule
